// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS core: sequences fetch, decode,
// execute, memory and write-back, with bounded waits on memory ready.
module multicycle_control #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       pc_en,
   output logic       is_branch,
   output logic       is_jump,
   output logic       ir_write,
   output logic       imem_read,
   output logic       dmem_read,
   output logic       dmem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [3:0] state,
   output logic       retire,
   output logic       illegal,
   output logic       bus_error
);

   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMRD    = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWR    = 4'd5;
   localparam logic [3:0] EXEC     = 4'd6;
   localparam logic [3:0] ALUWB    = 4'd7;
   localparam logic [3:0] BRANCH   = 4'd8;
   localparam logic [3:0] ADDIEXEC = 4'd9;
   localparam logic [3:0] ADDIWB   = 4'd10;
   localparam logic [3:0] JUMP     = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   logic [3:0]    state_q;
   logic [3:0]    state_d;
   logic [CW-1:0] wait_cnt;
   logic          cnt_inc;
   logic          timed_out;

   // The counter only ever holds the number of cycles already spent waiting in
   // the current handshake state, so reaching TMO means the limit is used up.
   assign timed_out = (TIMEOUT != 0) && (wait_cnt == TMO);

   always_comb begin
      pc_en      = 1'b0;
      is_branch  = 1'b0;
      is_jump    = 1'b0;
      ir_write   = 1'b0;
      imem_read  = 1'b0;
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      retire     = 1'b0;
      illegal    = 1'b0;
      bus_error  = 1'b0;
      cnt_inc    = 1'b0;
      state_d    = state_q;
      case (state_q)
         FETCH: begin
            imem_read = 1'b1;
            if (imem_ready) begin
               ir_write = 1'b1;
               pc_en    = 1'b1;
               state_d  = DECODE;
            end else if (timed_out) begin
               bus_error = 1'b1;
               state_d   = FETCH;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXEC;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEXEC;
               OP_J:         state_d = JUMP;
               default: begin
                  illegal = 1'b1;
                  state_d = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alu_src_b = 2'b01;
            state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            dmem_read = 1'b1;
            if (dmem_ready) begin
               state_d = MEMWB;
            end else if (timed_out) begin
               bus_error = 1'b1;
               state_d   = FETCH;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_d    = FETCH;
         end
         MEMWR: begin
            dmem_write = 1'b1;
            if (dmem_ready) begin
               retire  = 1'b1;
               state_d = FETCH;
            end else if (timed_out) begin
               bus_error = 1'b1;
               state_d   = FETCH;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         EXEC: begin
            alu_op  = 2'b10;
            state_d = ALUWB;
         end
         ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         BRANCH: begin
            alu_op    = 2'b01;
            is_branch = 1'b1;
            pc_en     = zero;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         ADDIEXEC: begin
            alu_src_b = 2'b01;
            state_d   = ADDIWB;
         end
         ADDIWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         JUMP: begin
            is_jump = 1'b1;
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
      // Reset squashes every strobe immediately, even mid-instruction.
      if (reset) begin
         pc_en      = 1'b0;
         is_branch  = 1'b0;
         is_jump    = 1'b0;
         ir_write   = 1'b0;
         imem_read  = 1'b0;
         dmem_read  = 1'b0;
         dmem_write = 1'b0;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         alu_src_b  = 2'b00;
         alu_op     = 2'b00;
         retire     = 1'b0;
         illegal    = 1'b0;
         bus_error  = 1'b0;
      end
   end

   assign state = reset ? FETCH : state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= FETCH;
         wait_cnt <= '0;
      end else begin
         state_q  <= state_d;
         wait_cnt <= cnt_inc ? wait_cnt + CW'(1) : '0;
      end
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS core; sequences the IFU, register file, ALU and data memory.
- Drives the IFU's PC update (pc_en, is_branch, is_jump) and waits on ready handshakes from instruction and data memory.
- Supports R-type (000000), lw (100011), sw (101011), beq (000100), j (000010) and addi (001000).
- Any other opcode is flagged illegal and skipped.

Parameters:
TIMEOUT, 15, max cycles to wait for a memory ready; exceeding it aborts the instruction; 0 disables the timeout.

Ports:
clk  input  1  clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset.
opcode  input  6  instruction[31:26] from the instruction register.
zero  input  1  ALU zero flag (beq compare).
imem_ready  input  1  instruction memory has valid data this cycle.
dmem_ready  input  1  data memory read/write completes this cycle.
pc_en  output  1  IFU PC register write enable.
is_branch  output  1  IFU next-PC select: PC+4+(sext(imm16)<<2).
is_jump  output  1  IFU next-PC select: {PC[31:28],addr26,2'b00}.
ir_write  output  1  latch fetched instruction.
imem_read  output  1  instruction memory read request.
dmem_read  output  1  data memory read request.
dmem_write  output  1  data memory write request.
reg_write  output  1  register file write enable.
reg_dst  output  1  1 = rd, 0 = rt.
mem_to_reg  output  1  1 = write-back from MDR, 0 = from ALUOut.
alu_src_b  output  2  00 = rt, 01 = sext imm16.
alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded.
state  output  4  current state encoding, for debug.
retire  output  1  one-cycle pulse when an instruction completes.
illegal  output  1  one-cycle pulse on an unsupported opcode.
bus_error  output  1  one-cycle pulse on a memory timeout.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable and map to FETCH on the next edge.
- Reset:
  - state=FETCH and wait counter=0 on any cycle where reset=1, including mid-instruction.
  - While reset=1, all outputs are 0 except state=0.
- Outputs are a combinational decode of state, opcode, zero and the ready inputs. Signals not listed for a state are 0.
- Memory handshake (FETCH, MEMRD, MEMWR):
  - The request is held high every cycle until ready=1 or timeout.
  - The wait counter increments each non-ready cycle and clears on leaving the state.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with ready=0: bus_error=1 that cycle, go to FETCH, no register/PC/memory side effect.
- FETCH:
  - imem_read=1.
  - If imem_ready=1: ir_write=1, pc_en=1 (is_branch=0, is_jump=0, so PC+=4), next state DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle): next state by opcode.
  - lw/sw -> MEMADR
  - R-type -> EXEC
  - beq -> BRANCH
  - addi -> ADDIEXEC
  - j -> JUMP
  - any other opcode: illegal=1, -> FETCH (the already-incremented PC is kept).
- MEMADR: alu_src_b=01, alu_op=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD:
  - dmem_read=1.
  - If dmem_ready=1 -> MEMWB; otherwise hold.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, retire=1. Next state FETCH.
- MEMWR:
  - dmem_write=1.
  - If dmem_ready=1: retire=1, -> FETCH.
- EXEC: alu_src_b=00, alu_op=10. Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1. Next state FETCH.
- BRANCH:
  - alu_src_b=00, alu_op=01, is_branch=1.
  - pc_en=zero (PC changes only when taken).
  - retire=1, -> FETCH.
- ADDIEXEC: alu_src_b=01, alu_op=00. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1. Next state FETCH.
- JUMP: is_jump=1, pc_en=1, retire=1. Next state FETCH.
- Invariants:
  - is_branch and is_jump are never both 1.
  - pc_en is only ever 1 in FETCH, BRANCH or JUMP.
  - At most one of dmem_read/dmem_write is high.
- Latency with zero wait states (cycles including FETCH):
  - lw = 5
  - sw = 4
  - R-type = 4
  - addi = 4
  - beq = 3
  - j = 3
  - illegal = 2

Test Plan:
- Reset asserted in MEMRD (lw, dmem_ready=0) -> next edge state=0; dmem_read=0; no reg_write/retire; following fetch proceeds normally.
- imem_ready tied 1; sequence addi, R-type, lw, sw with dmem_ready=1 -> state traces 0,1,9,10 / 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5; retire pulses at cycles 4, 8, 13, 17; reg_dst=1 only in ALUWB.
- beq with zero=0, then beq with zero=1 -> BRANCH: is_branch=1 both times; pc_en=0 then 1.
- j -> JUMP state with is_jump=1 and pc_en=1 for exactly one cycle; never together with is_branch.
- lw with dmem_ready low 3 cycles, then high -> MEMRD held 4 cycles with dmem_read=1; MEMWB follows; no bus_error.
- TIMEOUT=15, imem_ready=0 forever -> bus_error pulse after 15 wait cycles; return to FETCH; pc_en never 1.
- TIMEOUT=15, opcode 111111 -> illegal pulse in DECODE, then FETCH.
